// File: rtl/pipe_ctrl.sv
// Pipeline control: cumulative stall merge, multi-cycle flush sequencing with redirect PC,
// stall watchdog. Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_ctrl #(
  parameter int unsigned STAGES    = 6,
  parameter int unsigned FLUSH_LEN = 1,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic              flush_req_i,
  input  logic [31:0]       flush_pc_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              stall_timeout_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_count_o
);

  localparam int unsigned LenW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam logic [LenW-1:0] LenMax = LenW'(FLUSH_LEN - 1);
  localparam logic [WdW-1:0]  WdMax  = WdW'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e            state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [31:0]       pc_q, pc_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic              tmo_q, tmo_d;
  logic [STAGES-1:0] stall_merge;
  logic              stalling;
  logic              flush_start;

  // A stall at stage k must also hold every older stage below it.
  always_comb begin
    logic acc;
    acc         = 1'b0;
    stall_merge = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc            = acc | stallreq_i[k];
      stall_merge[k] = acc;
    end
  end

  assign stall_o         = (rst && (state_q == StIdle)) ? stall_merge : '0;
  assign stalling        = |stall_o;
  assign flush_o         = (state_q == StFlush);
  assign new_pc_o        = pc_q;
  assign stall_timeout_o = tmo_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    pc_d        = pc_q;
    wd_d        = wd_q;
    tmo_d       = tmo_q;
    flush_start = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flush_req_i) begin
          state_d     = StFlush;
          pc_d        = flush_pc_i;
          len_d       = LenMax;
          flush_start = 1'b1;
        end
      end
      StFlush: begin
        if (flush_req_i) begin
          pc_d  = flush_pc_i;
          len_d = LenMax;
        end else if (len_q == '0) begin
          state_d = StIdle;
        end else begin
          len_d = len_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_start) begin
      wd_d  = '0;
      tmo_d = 1'b0;
    end else if (stalling) begin
      if (wd_q != WdMax) wd_d = wd_q + 1'b1;
      // This edge closes the TIMEOUT-th consecutive stall cycle.
      if (wd_q >= WdMax - 1'b1) tmo_d = 1'b1;
    end else begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      pc_q    <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Restarts during a flush count as new flushes.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stalling && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    if (flush_req_i && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: instance a (FLUSH_LEN=1, TIMEOUT=4, CNT_W=4) and
// instance b (FLUSH_LEN=3); expectations are queued then compared after each step.
module tb_pipe_ctrl;

  localparam int unsigned CntW = 4;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  localparam int KStall = 0;
  localparam int KFlush = 1;
  localparam int KPc    = 2;
  localparam int KTmo   = 3;
  localparam int KSc    = 4;
  localparam int KFc    = 5;

  typedef struct {
    string       tag;
    int          dut;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  a_sr, b_sr;
  logic        a_fr, b_fr;
  logic [31:0] a_pc, b_pc;
  logic [5:0]  a_stall, b_stall;
  logic        a_flush, b_flush;
  logic [31:0] a_npc, b_npc;
  logic        a_tmo, b_tmo;
  logic [CntW-1:0] a_sc, a_fc;
  logic [31:0] b_sc, b_fc;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(6), .FLUSH_LEN(1), .TIMEOUT(4), .CNT_W(CntW)) u_a (
    .clk             (clk),
    .rst             (rst),
    .stallreq_i      (a_sr),
    .flush_req_i     (a_fr),
    .flush_pc_i      (a_pc),
    .stall_o         (a_stall),
    .flush_o         (a_flush),
    .new_pc_o        (a_npc),
    .stall_timeout_o (a_tmo),
    .stall_cycles_o  (a_sc),
    .flush_count_o   (a_fc)
  );

  pipe_ctrl #(.STAGES(6), .FLUSH_LEN(3), .TIMEOUT(255), .CNT_W(32)) u_b (
    .clk             (clk),
    .rst             (rst),
    .stallreq_i      (b_sr),
    .flush_req_i     (b_fr),
    .flush_pc_i      (b_pc),
    .stall_o         (b_stall),
    .flush_o         (b_flush),
    .new_pc_o        (b_npc),
    .stall_timeout_o (b_tmo),
    .stall_cycles_o  (b_sc),
    .flush_count_o   (b_fc)
  );

  function automatic logic [31:0] observe(input int dut, input int kind);
    logic [31:0] v;
    v = '0;
    if (dut == 0) begin
      case (kind)
        KStall:  v = 32'(a_stall);
        KFlush:  v = 32'(a_flush);
        KPc:     v = a_npc;
        KTmo:    v = 32'(a_tmo);
        KSc:     v = 32'(a_sc);
        default: v = 32'(a_fc);
      endcase
    end else begin
      case (kind)
        KStall:  v = 32'(b_stall);
        KFlush:  v = 32'(b_flush);
        KPc:     v = b_npc;
        KTmo:    v = 32'(b_tmo);
        KSc:     v = b_sc;
        default: v = b_fc;
      endcase
    end
    return v;
  endfunction

  task automatic expect_val(input string tag, input int dut, input int kind,
                            input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.dut  = dut;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.dut, e.kind);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_sr = 6'b000100; a_fr = 1'b1; a_pc = 32'h40;
    b_sr = 6'b000100; b_fr = 1'b1; b_pc = 32'h40;
    rst  = 1'b0;
    tick();
    tick();
    expect_val("rst_stall", 0, KStall, 32'h0);
    expect_val("rst_flush", 0, KFlush, 32'h0);
    expect_val("rst_pc",    0, KPc,    32'h0);
    expect_val("rst_tmo",   0, KTmo,   32'h0);
    expect_val("rst_sc",    0, KSc,    32'h0);
    expect_val("rst_fc",    0, KFc,    32'h0);
    expect_val("rst_b_flush", 1, KFlush, 32'h0);
    expect_val("rst_b_stall", 1, KStall, 32'h0);
    check_all();

    // Combinational stall merge within one cycle.
    rst = 1'b1; a_fr = 1'b0; b_fr = 1'b0; b_sr = 6'b0;
    a_sr = 6'b000010; #1;
    expect_val("merge_02", 0, KStall, 32'h03); check_all();
    a_sr = 6'b001010; #1;
    expect_val("merge_0a", 0, KStall, 32'h0f); check_all();
    a_sr = 6'b000000; #1;
    expect_val("merge_00", 0, KStall, 32'h00); check_all();

    // Single-cycle flush.
    a_fr = 1'b1; a_pc = 32'h40; a_sr = 6'b000010;
    tick();
    a_fr = 1'b0;
    expect_val("fl1_flush", 0, KFlush, 32'h1);
    expect_val("fl1_pc",    0, KPc,    32'h40);
    expect_val("fl1_stall", 0, KStall, 32'h0);
    check_all();
    tick();
    expect_val("fl1_end_flush", 0, KFlush, 32'h0);
    expect_val("fl1_end_stall", 0, KStall, 32'h03);
    expect_val("fl1_end_pc",    0, KPc,    32'h40);
    expect_val("fl1_fc",        0, KFc,    Perf ? 32'd1 : 32'd0);
    check_all();
    a_sr = 6'b0;

    // Watchdog: 4 consecutive stall cycles set the sticky flag.
    a_sr = 6'b000010;
    tick(); tick(); tick();
    expect_val("wd_3", 0, KTmo, 32'h0); check_all();
    tick();
    expect_val("wd_4", 0, KTmo, 32'h1); check_all();
    a_sr = 6'b0;
    tick();
    expect_val("wd_sticky", 0, KTmo, 32'h1); check_all();
    a_fr = 1'b1; a_pc = 32'h80;
    tick();
    a_fr = 1'b0;
    expect_val("wd_clr_tmo", 0, KTmo, 32'h0);
    expect_val("wd_clr_pc",  0, KPc,  32'h80);
    expect_val("wd_clr_fl",  0, KFlush, 32'h1);
    check_all();
    tick();
    expect_val("fc_2", 0, KFc, Perf ? 32'd2 : 32'd0); check_all();

    a_sr = 6'b000010;
    tick(); tick(); tick();
    a_sr = 6'b0;
    tick();
    expect_val("wd_3_release", 0, KTmo, 32'h0); check_all();

    // 8 stall cycles so far; 20 more saturate the 4-bit counter.
    a_sr = 6'b000010;
    repeat (20) tick();
    expect_val("sc_sat",  0, KSc,  Perf ? 32'd15 : 32'd0);
    expect_val("wd_long", 0, KTmo, 32'h1);
    check_all();
    a_sr = 6'b0;

    // Three-cycle flush with a restart; latest PC wins.
    b_sr = 6'b000001; b_fr = 1'b1; b_pc = 32'h40;
    tick();
    expect_val("b_t1_flush", 1, KFlush, 32'h1);
    expect_val("b_t1_pc",    1, KPc,    32'h40);
    expect_val("b_t1_stall", 1, KStall, 32'h0);
    check_all();
    b_pc = 32'h80;
    tick();
    b_fr = 1'b0;
    expect_val("b_t2_flush", 1, KFlush, 32'h1);
    expect_val("b_t2_pc",    1, KPc,    32'h80);
    check_all();
    tick();
    expect_val("b_t3_flush", 1, KFlush, 32'h1);
    expect_val("b_t3_stall", 1, KStall, 32'h0);
    check_all();
    tick();
    expect_val("b_t4_flush", 1, KFlush, 32'h1); check_all();
    tick();
    expect_val("b_t5_flush", 1, KFlush, 32'h0);
    expect_val("b_t5_pc",    1, KPc,    32'h80);
    expect_val("b_t5_stall", 1, KStall, 32'h01);
    check_all();
    b_sr = 6'b0;

    // Reset in the middle of a flush.
    a_fr = 1'b1; a_pc = 32'hc0;
    tick();
    a_fr = 1'b0; a_sr = 6'b000001;
    expect_val("mid_flush", 0, KFlush, 32'h1);
    expect_val("mid_pc",    0, KPc,    32'hc0);
    check_all();
    rst = 1'b0; #1;
    expect_val("mid_rst_stall", 0, KStall, 32'h0); check_all();
    tick();
    expect_val("mid_rst_flush", 0, KFlush, 32'h0);
    expect_val("mid_rst_pc",    0, KPc,    32'h0);
    expect_val("mid_rst_tmo",   0, KTmo,   32'h0);
    expect_val("mid_rst_sc",    0, KSc,    32'h0);
    expect_val("mid_rst_fc",    0, KFc,    32'h0);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
